// File: rtl/serial_receiver.sv
// serial_receiver: oversampled serial frame receiver with a ready/read output handshake.
// Even-parity bit support is compiled in by defining SERIAL_RX_PARITY_EN.
module serial_receiver #(
   parameter int unsigned DataLen    = 8,
   parameter int unsigned ClksPerBit = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               serial_line,
   output logic [DataLen-1:0] data_out,
   output logic               data_ready,
   input  logic               read_data,
   output logic               parity_error,
   output logic               frame_error,
   output logic               overrun
);

   localparam int unsigned CntW = $clog2(ClksPerBit);
   localparam int unsigned IdxW = $clog2(DataLen + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
   localparam logic [CntW-1:0] CntMid  = CntW'(ClksPerBit / 2 - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(DataLen - 1);

`ifdef SERIAL_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t              state_q;
   state_t              state_d;
   logic                sync_q;
   logic                rx_s;
   logic                rx_prev;
   logic [CntW-1:0]     cnt_q;
   logic [IdxW-1:0]     bit_idx_q;
   logic [DataLen-1:0]  shift_q;
   logic                sample_c;
   logic                fall_c;
   logic                deliver_c;
   logic                load_c;

   // Counter is held at zero in IDLE, so every sample point lands on CntMid.
   assign sample_c = (cnt_q == CntMid);
   assign fall_c   = rx_prev & ~rx_s;
   assign load_c   = deliver_c & (~data_ready | read_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      deliver_c = 1'b0;
      case (state_q)
         S_IDLE:  if (fall_c) state_d = S_START;
         S_START: if (sample_c) state_d = rx_s ? S_IDLE : S_DATA;
         S_DATA: begin
            if (sample_c && (bit_idx_q == IdxLast)) begin
`ifdef SERIAL_RX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
         end
`ifdef SERIAL_RX_PARITY_EN
         S_PARITY: if (sample_c) state_d = S_STOP;
`endif
         S_STOP: begin
            if (sample_c) begin
               state_d   = S_IDLE;
               deliver_c = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Two-flop synchronizer plus one history flop for falling-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync_q  <= serial_line;
         rx_s    <= sync_q;
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         if ((state_q == S_IDLE) || (cnt_q == CntLast)) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
         if (state_q == S_IDLE) begin
            bit_idx_q <= '0;
         end else if ((state_q == S_DATA) && sample_c) begin
            shift_q   <= {rx_s, shift_q[DataLen-1:1]};
            bit_idx_q <= bit_idx_q + IdxW'(1);
         end
      end
   end

   // A read coinciding with delivery frees the slot, so the new byte wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out    <= '0;
         data_ready  <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else if (load_c) begin
         data_out    <= shift_q;
         data_ready  <= 1'b1;
         frame_error <= ~rx_s;
         if (read_data) overrun <= 1'b0;
      end else if (deliver_c) begin
         overrun <= 1'b1;
      end else if (read_data && data_ready) begin
         data_ready <= 1'b0;
         overrun    <= 1'b0;
      end
   end

`ifdef SERIAL_RX_PARITY_EN
   logic par_bad_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_bad_q    <= 1'b0;
         parity_error <= 1'b0;
      end else begin
         if ((state_q == S_PARITY) && sample_c) par_bad_q <= (^shift_q) ^ rx_s;
         if (load_c) parity_error <= par_bad_q;
      end
   end
`else
   assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: directed frames, a frame-level scoreboard model
// compared every cycle, and literal spot checks on key scenarios.
module tb_serial_receiver;

   localparam int unsigned DL  = 8;
   localparam int unsigned CPB = 4;
   localparam int unsigned H   = CPB / 2;
`ifdef SERIAL_RX_PARITY_EN
   localparam int unsigned PAR = 1;
`else
   localparam int unsigned PAR = 0;
`endif
   localparam int unsigned FRAME = CPB * (DL + 2 + PAR);

   logic          clk;
   logic          rst;
   logic          serial_line;
   logic [DL-1:0] data_out;
   logic          data_ready;
   logic          read_data;
   logic          parity_error;
   logic          frame_error;
   logic          overrun;

   serial_receiver #(.DataLen(DL), .ClksPerBit(CPB)) dut (
      .clk          (clk),
      .rst          (rst),
      .serial_line  (serial_line),
      .data_out     (data_out),
      .data_ready   (data_ready),
      .read_data    (read_data),
      .parity_error (parity_error),
      .frame_error  (frame_error),
      .overrun      (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic abort = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Frame-level scoreboard: each driven frame is due on a known edge.
   typedef struct {
      int            due;
      logic [DL-1:0] data;
      logic          perr;
      logic          ferr;
   } frame_t;

   frame_t        pend[$];
   logic [DL-1:0] m_data  = '0;
   logic          m_ready = 1'b0;
   logic          m_perr  = 1'b0;
   logic          m_ferr  = 1'b0;
   logic          m_ovr   = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend.delete();
         m_data = '0; m_ready = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      end else if (pend.size() > 0 && pend[0].due == cyc + 1) begin
         if (!m_ready || read_data) begin
            m_data  = pend[0].data;
            m_perr  = pend[0].perr;
            m_ferr  = pend[0].ferr;
            m_ready = 1'b1;
            m_ovr   = 1'b0;
         end else begin
            m_ovr = 1'b1;
         end
         void'(pend.pop_front());
      end else if (read_data && m_ready) begin
         m_ready = 1'b0;
         m_ovr   = 1'b0;
      end
   end

   always @(negedge clk) begin
      chk("cmp data_out", 32'(data_out), 32'(m_data));
      chk("cmp data_ready", 32'(data_ready), 32'(m_ready));
      chk("cmp parity_error", 32'(parity_error), 32'(m_perr));
      chk("cmp frame_error", 32'(frame_error), 32'(m_ferr));
      chk("cmp overrun", 32'(overrun), 32'(m_ovr));
   end

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_read();
      read_data = 1'b1;
      align();
      read_data = 1'b0;
   endtask

   // Called just after an edge; returns just after the edge ending the stop bit,
   // leaving the line at the stop level.
   task automatic send_frame(input logic [DL-1:0] d, input logic par, input logic stp);
      frame_t f;
      int t0;
      int nb;
      logic b;
      t0     = cyc + 2;
      f.due  = t0 + int'(H) + int'((DL + 1 + PAR) * CPB) + 1;
      f.data = d;
      f.perr = (PAR != 0) ? ((^d) ^ par) : 1'b0;
      f.ferr = ~stp;
      pend.push_back(f);
      nb = int'(DL + 2 + PAR);
      for (int i = 0; i < nb; i++) begin
         if (abort) begin
            serial_line = 1'b1;
            return;
         end
         if (i == 0)                b = 1'b0;
         else if (i <= int'(DL))    b = d[i-1];
         else if (i == nb - 1)      b = stp;
         else                       b = par;
         serial_line = b;
         idle(int'(CPB));
      end
   endtask

   logic exp_pe;

   initial begin
      exp_pe      = (PAR != 0);
      serial_line = 1'b1;
      read_data   = 1'b0;
      rst         = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset data_out", 32'(data_out), 32'h0);
      chk("reset data_ready", 32'(data_ready), 32'h0);
      chk("reset parity_error", 32'(parity_error), 32'h0);
      chk("reset frame_error", 32'(frame_error), 32'h0);
      chk("reset overrun", 32'(overrun), 32'h0);
      align();
      idle(5);

      // Valid frame: data_ready rises exactly one cycle after the stop sample.
      send_frame(8'h33, 1'b0, 1'b1);
      @(negedge clk);
      chk("valid ready at stop sample", 32'(data_ready), 32'h0);
      @(negedge clk);
      chk("valid ready", 32'(data_ready), 32'h1);
      chk("valid data", 32'(data_out), 32'h33);
      chk("valid perr", 32'(parity_error), 32'h0);
      chk("valid ferr", 32'(frame_error), 32'h0);
      align();
      pulse_read();
      @(negedge clk);
      chk("valid read clears", 32'(data_ready), 32'h0);
      align();

      // Parity error then a clean byte.
      send_frame(8'h0F, 1'b1, 1'b1);
      align();
      @(negedge clk);
      chk("par data", 32'(data_out), 32'h0F);
      chk("par perr", 32'(parity_error), 32'(exp_pe));
      align();
      pulse_read();
      send_frame(8'hA5, 1'b0, 1'b1);
      align();
      @(negedge clk);
      chk("a5 data", 32'(data_out), 32'hA5);
      chk("a5 perr", 32'(parity_error), 32'h0);
      align();
      pulse_read();

      // False start: one-cycle glitch.
      serial_line = 1'b0;
      align();
      serial_line = 1'b1;
      idle(12);
      @(negedge clk);
      chk("false start", 32'(data_ready), 32'h0);
      align();

      // Framing error followed by a held-low break.
      send_frame(8'h3C, 1'b0, 1'b0);
      align();
      @(negedge clk);
      chk("ferr flag", 32'(frame_error), 32'h1);
      chk("ferr data", 32'(data_out), 32'h3C);
      align();
      pulse_read();
      idle(20);
      @(negedge clk);
      chk("break no frame", 32'(data_ready), 32'h0);
      align();
      serial_line = 1'b1;
      idle(6);

      // Overrun: second byte dropped while the first is unread.
      send_frame(8'h11, 1'b0, 1'b1);
      idle(3);
      send_frame(8'h22, 1'b0, 1'b1);
      align();
      @(negedge clk);
      chk("ovr data held", 32'(data_out), 32'h11);
      chk("ovr flag", 32'(overrun), 32'h1);
      chk("ovr ready", 32'(data_ready), 32'h1);
      align();
      pulse_read();
      @(negedge clk);
      chk("ovr read ready", 32'(data_ready), 32'h0);
      chk("ovr read flag", 32'(overrun), 32'h0);
      align();

      // Read on the same edge the new byte is delivered.
      send_frame(8'h11, 1'b0, 1'b1);
      idle(3);
      send_frame(8'h22, 1'b0, 1'b1);
      read_data = 1'b1;
      align();
      read_data = 1'b0;
      @(negedge clk);
      chk("simul data", 32'(data_out), 32'h22);
      chk("simul ready", 32'(data_ready), 32'h1);
      chk("simul ovr", 32'(overrun), 32'h0);
      align();

      // Reset in the middle of a frame.
      fork
         send_frame(8'h5A, 1'b0, 1'b1);
         begin
            repeat (18) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("midrst data_out", 32'(data_out), 32'h0);
            chk("midrst data_ready", 32'(data_ready), 32'h0);
            chk("midrst overrun", 32'(overrun), 32'h0);
            abort = 1'b1;
         end
      join
      abort = 1'b0;
      idle(3);
      rst = 1'b0;
      idle(4);
      send_frame(8'hC3, 1'b0, 1'b1);
      align();
      @(negedge clk);
      chk("c3 data", 32'(data_out), 32'hC3);
      chk("c3 ready", 32'(data_ready), 32'h1);
      chk("c3 ferr", 32'(frame_error), 32'h0);
      align();
      pulse_read();
      idle(3);

      // Back-to-back frames, first byte read while the second is in flight.
      fork
         begin
            send_frame(8'h80, 1'b1, 1'b1);
            send_frame(8'h01, 1'b1, 1'b1);
         end
         begin
            idle(int'(FRAME) + 2);
            @(negedge clk);
            chk("b2b first", 32'(data_out), 32'h80);
            align();
            pulse_read();
         end
      join
      align();
      @(negedge clk);
      chk("b2b second", 32'(data_out), 32'h01);
      chk("b2b ready", 32'(data_ready), 32'h1);
      chk("b2b ovr", 32'(overrun), 32'h0);
      align();
      idle(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
